game_fsm: RTL and testbench

GAME_FSM -- requirements
Module: game_fsm

---
 rtl/game_pkg.sv | 30 +++
 rtl/key_edge.sv | 29 ++
 rtl/game_fsm.sv | 153 +++++++++++++++
 tb/tb_game_fsm.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// game_pkg -- shared definitions for the game control logic.
//   game_state_t     : FSM state encoding (IDLE=0, PLAY=1, DYING=2, OVER=3)
//   SCORE_W          : score width in bits
//   SCORE_MAX_DEF    : default score saturation value
//   FRAME_DIV_DEF    : clk cycles per frame (60 Hz at 65 MHz), also used by
//                      bird_ctrl's frame generator
//   DEATH_FRAMES_DEF : default number of frames spent in DYING
//   score_inc()      : saturating score increment
package game_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PLAY  = 2'd1,
    DYING = 2'd2,
    OVER  = 2'd3
  } game_state_t;

  localparam int SCORE_W          = 10;
  localparam int SCORE_MAX_DEF    = 999;
  localparam int FRAME_DIV_DEF    = 1083333;
  localparam int DEATH_FRAMES_DEF = 60;

  function automatic logic [SCORE_W-1:0] score_inc(
    input logic [SCORE_W-1:0] cur,
    input logic [SCORE_W-1:0] lim
  );
    return (cur >= lim) ? lim : cur + 1'b1;
  endfunction

endpackage

// File: rtl/key_edge.sv
// key_edge -- two-flop synchronizer plus rising-edge detector for the
// start key.
//   clk      : system clock
//   rst_n    : asynchronous active-low reset, clears both flops
//   key_in   : raw level from the key (active-high)
//   key_rise : one-cycle pulse, high while d0=1 and d1=0
module key_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic key_in,
  output logic key_rise
);

  logic d0;
  logic d1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d0 <= 1'b0;
      d1 <= 1'b0;
    end else begin
      d0 <= key_in;
      d1 <= d0;
    end
  end

  assign key_rise = d0 & ~d1;

endmodule

// File: rtl/game_fsm.sv
// game_fsm -- top-level game sequencer: frame timer, start-key edge
// detection, IDLE/PLAY/DYING/OVER state machine, score and best score.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for start key; score holds last game's result
// PLAY  | bird flying, pipes scrolling, pipe_passed scores
// DYING | collision seen, bird falls for DEATH_FRAMES frames
// OVER  | game over screen, start key returns to IDLE
//
// Ports:
//   clk, rst_n   : system clock, asynchronous active-low reset
//   key_start    : start/restart key level (active-high)
//   collide      : collision level
//   pipe_passed  : one-cycle pulse per pipe cleared
//   frame_tick   : one-cycle pulse at the last count of each frame
//   game_active  : bird physics enable (PLAY or DYING)
//   scroll_en    : scroll enable (PLAY)
//   state        : current state encoding
//   score        : current score (saturating)
//   best_score   : session high score
//   game_over    : high in OVER
//
// Build option: define GAME_FSM_BEST_SCORE_EN to keep a best-score
// register; otherwise best_score is tied to zero.
module game_fsm #(
  parameter int FRAME_DIV    = game_pkg::FRAME_DIV_DEF,
  parameter int DEATH_FRAMES = game_pkg::DEATH_FRAMES_DEF,
  parameter int SCORE_MAX    = game_pkg::SCORE_MAX_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_start,
  input  logic       collide,
  input  logic       pipe_passed,
  output logic       frame_tick,
  output logic       game_active,
  output logic       scroll_en,
  output logic [1:0] state,
  output logic [9:0] score,
  output logic [9:0] best_score,
  output logic       game_over
);

  import game_pkg::*;

  localparam int FC_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam int DC_W = (DEATH_FRAMES > 1) ? $clog2(DEATH_FRAMES) : 1;
  localparam logic [FC_W-1:0]    FC_LAST   = FC_W'(FRAME_DIV - 1);
  localparam logic [DC_W-1:0]    DC_LOAD   = DC_W'(DEATH_FRAMES - 1);
  localparam logic [SCORE_W-1:0] SCORE_LIM = SCORE_W'(SCORE_MAX);

  game_state_t        state_q, state_d;
  logic [FC_W-1:0]    frame_cnt;
  logic [DC_W-1:0]    death_q, death_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic               key_rise;

  key_edge u_key_edge (
    .clk      (clk),
    .rst_n    (rst_n),
    .key_in   (key_start),
    .key_rise (key_rise)
  );

  // Free-running frame counter, independent of game state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt <= '0;
    end else if (frame_cnt == FC_LAST) begin
      frame_cnt <= '0;
    end else begin
      frame_cnt <= frame_cnt + 1'b1;
    end
  end

  assign frame_tick = (frame_cnt == FC_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      death_q <= '0;
      score_q <= '0;
    end else begin
      state_q <= state_d;
      death_q <= death_d;
      score_q <= score_d;
    end
  end

  // Death timer is a down-counter of remaining frames: loaded with
  // DEATH_FRAMES-1 on DYING entry, terminal on a tick while at zero.
  always_comb begin
    state_d = state_q;
    death_d = death_q;
    score_d = score_q;
    case (state_q)
      IDLE: begin
        if (key_rise) begin
          state_d = PLAY;
          score_d = '0;
        end
      end
      PLAY: begin
        // collision takes priority over a same-cycle pipe pass
        if (collide) begin
          state_d = DYING;
          death_d = DC_LOAD;
        end else if (pipe_passed) begin
          score_d = score_inc(score_q, SCORE_LIM);
        end
      end
      DYING: begin
        if (frame_tick) begin
          if (death_q == '0) begin
            state_d = OVER;
          end else begin
            death_d = death_q - 1'b1;
          end
        end
      end
      OVER: begin
        if (key_rise) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef GAME_FSM_BEST_SCORE_EN
  logic [SCORE_W-1:0] best_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      best_q <= '0;
    end else if (state_q == DYING && state_d == OVER && score_q > best_q) begin
      best_q <= score_q;
    end
  end

  assign best_score = best_q;
`else
  assign best_score = '0;
`endif

  assign state       = state_q;
  assign score       = score_q;
  assign game_active = (state_q == PLAY) || (state_q == DYING);
  assign scroll_en   = (state_q == PLAY);
  assign game_over   = (state_q == OVER);

endmodule

// File: tb/tb_game_fsm.sv
module tb_game_fsm;

  localparam int FD   = 10;
  localparam int DF   = 3;
  localparam int SMAX = 999;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       key_start = 1'b0;
  logic       collide = 1'b0;
  logic       pipe_passed = 1'b0;
  logic       frame_tick;
  logic       game_active;
  logic       scroll_en;
  logic [1:0] state;
  logic [9:0] score;
  logic [9:0] best_score;
  logic       game_over;

  game_fsm #(.FRAME_DIV(FD), .DEATH_FRAMES(DF), .SCORE_MAX(SMAX)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .key_start   (key_start),
    .collide     (collide),
    .pipe_passed (pipe_passed),
    .frame_tick  (frame_tick),
    .game_active (game_active),
    .scroll_en   (scroll_en),
    .state       (state),
    .score       (score),
    .best_score  (best_score),
    .game_over   (game_over)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // reference model: 0 idle, 1 play, 2 dying, 3 over
  int m_phase;
  int m_score;
  int m_best;
  int m_frames_dead;
  int m_edges;
  bit m_key1, m_key2;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_score = 0; m_best = 0; m_frames_dead = 0;
    m_edges = 0; m_key1 = 0; m_key2 = 0;
  endtask

  task automatic model_edge();
    bit tick, rise;
    tick = (m_edges % FD) == FD - 1;
    rise = m_key1 && !m_key2;
    case (m_phase)
      0: if (rise) begin m_phase = 1; m_score = 0; end
      1: begin
        if (collide) begin m_phase = 2; m_frames_dead = 0; end
        else if (pipe_passed && m_score < SMAX) m_score++;
      end
      2: if (tick) begin
        m_frames_dead++;
        if (m_frames_dead == DF) begin
          m_phase = 3;
          if (m_score > m_best) m_best = m_score;
        end
      end
      default: if (rise) m_phase = 0;
    endcase
    m_key2 = m_key1;
    m_key1 = key_start;
    m_edges++;
  endtask

  task automatic compare_all();
    int exp_best;
`ifdef GAME_FSM_BEST_SCORE_EN
    exp_best = m_best;
`else
    exp_best = 0;
`endif
    chk("frame_tick",  frame_tick,  (m_edges % FD) == FD - 1);
    chk("state",       state,       m_phase);
    chk("score",       score,       m_score);
    chk("best_score",  best_score,  exp_best);
    chk("game_active", game_active, m_phase == 1 || m_phase == 2);
    chk("scroll_en",   scroll_en,   m_phase == 1);
    chk("game_over",   game_over,   m_phase == 3);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    #1 rst_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    repeat (3) @(posedge clk);
    #1;
    compare_all();
    rst_n = 1'b1;
  endtask

  task automatic wait_over(input string tag);
    for (int i = 0; i < 80 && state != 2'd3; i++) step();
    chk(tag, state, 3);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int starts;
    logic [1:0] prev;
    int exp_b;

    model_reset();
    do_reset();

    // idle, frame ticks only
    repeat (30) step();

    // key held 5 cycles -> exactly one start
    starts = 0;
    prev = state;
    key_start = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      if (prev == 2'd0 && state == 2'd1) starts++;
      prev = state;
    end
    key_start = 1'b0;
    repeat (3) begin
      step();
      if (prev == 2'd0 && state == 2'd1) starts++;
      prev = state;
    end
    chk("single_start", starts, 1);

    // 4 pipes, then collide and pipe together
    for (int i = 0; i < 4; i++) begin
      pipe_passed = 1'b1; step();
      pipe_passed = 1'b0; step();
    end
    collide = 1'b1; pipe_passed = 1'b1; step();
    collide = 1'b0; pipe_passed = 1'b0;
    chk("score_at_death", score, 4);
    chk("state_dying", state, 2);

    wait_over("reach_over_1");
`ifdef GAME_FSM_BEST_SCORE_EN
    exp_b = 4;
`else
    exp_b = 0;
`endif
    chk("best_after_game1", best_score, exp_b);

    // back to idle, then start again
    key_start = 1'b1; repeat (2) step();
    key_start = 1'b0; repeat (2) step();
    chk("back_idle", state, 0);
    key_start = 1'b1; step();
    key_start = 1'b0; repeat (2) step();
    chk("restart_play", state, 1);

    // saturation
    for (int i = 0; i < 1000; i++) begin
      pipe_passed = 1'b1; step();
      pipe_passed = 1'b0; step();
    end
    chk("score_saturated", score, SMAX);

    // reset mid-DYING
    collide = 1'b1; step();
    collide = 1'b0; repeat (4) step();
    chk("dying_before_reset", state, 2);
    do_reset();
    chk("reset_state", state, 0);
    chk("reset_score", score, 0);
    chk("reset_best", best_score, 0);

    // normal game after reset
    key_start = 1'b1; step();
    key_start = 1'b0; repeat (2) step();
    for (int i = 0; i < 2; i++) begin
      pipe_passed = 1'b1; step();
      pipe_passed = 1'b0; step();
    end
    collide = 1'b1; step();
    collide = 1'b0;
    wait_over("reach_over_2");
    chk("score_game2", score, 2);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 9) == 0) key_start = ~key_start;
      collide     = ($urandom_range(0, 24) == 0);
      pipe_passed = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 499) == 0) do_reset();
      else step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
